// File: rtl/divider_pkg.sv
// Shared types for the restoring divider: FSM state encoding and counter sizing.
// Used by divider_nbit; the optional signed mode is selected there with DIVIDER_SIGNED_EN.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PRECALC = 2'b01,
    CALC    = 2'b11,
    DONE    = 2'b10
  } state_t;

  // Bits needed to index every quotient bit from WIDTH-1 down to 0.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor at WIDTH+1 bits, keep the result if non-negative.
module divider_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The top bit of the trial difference is its sign: set means the divisor did not fit.
  always_comb begin
    shifted = {r, bit_in};
    trial   = shifted - {1'b0, divisor};
    q_bit   = ~trial[WIDTH];
    r_next  = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/divider_nbit.sv
// Parametrised sequential restoring divider with start/done handshake and divide-by-zero flag.
// Define DIVIDER_SIGNED_EN for two's-complement operands; the default build is unsigned.
module divider_nbit
  import divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strt,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             done,
  output logic             idle
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dsr_r;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] q_merge;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;
  logic             q_bit;
  logic [CW-1:0]    cnt;
`ifdef DIVIDER_SIGNED_EN
  logic             neg_q;
  logic             neg_r;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (strt) state_next = PRECALC;
      PRECALC: state_next = (dsr_r == '0) ? DONE : CALC;
      CALC:    if (cnt == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign idle = (state == IDLE);

  divider_step #(.WIDTH(WIDTH)) u_step (
    .r       (r_r),
    .bit_in  (dvd_r[cnt]),
    .divisor (dsr_r),
    .r_next  (r_step),
    .q_bit   (q_bit)
  );

  // Final quotient/remainder as they would stand after the current CALC step.
  always_comb begin
    q_merge      = q_r;
    q_merge[cnt] = q_bit;
    q_final      = q_merge;
    r_final      = r_step;
`ifdef DIVIDER_SIGNED_EN
    if (neg_q) q_final = -q_merge;
    if (neg_r) r_final = -r_step;
`endif
  end

  // Results are written on the edge entering DONE so they are valid while done is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvd_r       <= '0;
      dsr_r       <= '0;
      r_r         <= '0;
      q_r         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (strt) begin
            dvd_r <= dividend;
            dsr_r <= divisor;
          end
        end
        PRECALC: begin
          r_r <= '0;
          q_r <= '0;
          cnt <= CW'(WIDTH - 1);
          if (dsr_r == '0) begin
            quotient    <= '1;
            remainder   <= dvd_r;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
          end else begin
            div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            dvd_r <= dvd_r[WIDTH-1] ? -dvd_r : dvd_r;
            dsr_r <= dsr_r[WIDTH-1] ? -dsr_r : dsr_r;
            neg_q <= dvd_r[WIDTH-1] ^ dsr_r[WIDTH-1];
            neg_r <= dvd_r[WIDTH-1];
`endif
          end
        end
        CALC: begin
          r_r <= r_step;
          q_r <= q_merge;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            quotient  <= q_final;
            remainder <= r_final;
            done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_nbit.sv
// Self-checking bench for divider_nbit at WIDTH=8 and WIDTH=16, against an arithmetic model.
// Honours DIVIDER_SIGNED_EN the same way as the design.
module tb_divider_nbit;

  localparam int WD[2] = '{8, 16};

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        strt0 = 1'b0;
  logic        strt1 = 1'b0;
  logic [7:0]  dvd0 = '0;
  logic [7:0]  dvs0 = '0;
  logic [15:0] dvd1 = '0;
  logic [15:0] dvs1 = '0;
  logic [7:0]  q0, r0;
  logic [15:0] q1, r1;
  logic        dbz0, done0, idle0, dbz1, done1, idle1;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  divider_nbit #(.WIDTH(8)) dut0 (
    .clk(clk), .rst(rst), .strt(strt0), .dividend(dvd0), .divisor(dvs0),
    .quotient(q0), .remainder(r0), .div_by_zero(dbz0), .done(done0), .idle(idle0)
  );

  divider_nbit #(.WIDTH(16)) dut1 (
    .clk(clk), .rst(rst), .strt(strt1), .dividend(dvd1), .divisor(dvs1),
    .quotient(q1), .remainder(r1), .div_by_zero(dbz1), .done(done1), .idle(idle1)
  );

  logic [31:0] a_in[2], b_in[2], q_out[2], r_out[2];
  logic        s_in[2], dbz_out[2], done_out[2], idle_out[2];

  assign a_in[0] = 32'(dvd0);    assign a_in[1] = 32'(dvd1);
  assign b_in[0] = 32'(dvs0);    assign b_in[1] = 32'(dvs1);
  assign s_in[0] = strt0;        assign s_in[1] = strt1;
  assign q_out[0] = 32'(q0);     assign q_out[1] = 32'(q1);
  assign r_out[0] = 32'(r0);     assign r_out[1] = 32'(r1);
  assign dbz_out[0] = dbz0;      assign dbz_out[1] = dbz1;
  assign done_out[0] = done0;    assign done_out[1] = done1;
  assign idle_out[0] = idle0;    assign idle_out[1] = idle1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference division straight from the arithmetic definition.
  function automatic void ref_div(input int w, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
    longint mask = (longint'(1) << w) - 1;
    longint sa, sb, lq, lr;
    if (b == 0) begin
      q = 32'(mask);
      r = a;
      z = 1'b1;
    end else begin
`ifdef DIVIDER_SIGNED_EN
      sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
      sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
`else
      sa = longint'(a);
      sb = longint'(b);
`endif
      lq = sa / sb;
      lr = sa % sb;
      q  = 32'(lq & mask);
      r  = 32'(lr & mask);
      z  = 1'b0;
    end
  endfunction

  // Model timeline per unit: accept edge, flag clear after one cycle, result edge after latency.
  int          ec = 0;
  int          busy_last[2] = '{-10, -10};
  int          clr_edge[2]  = '{-10, -10};
  logic [31:0] eq[2] = '{32'd0, 32'd0};
  logic [31:0] er[2] = '{32'd0, 32'd0};
  logic [31:0] pq[2] = '{32'd0, 32'd0};
  logic [31:0] pr[2] = '{32'd0, 32'd0};
  logic        edbz[2]  = '{1'b0, 1'b0};
  logic        pdbz[2]  = '{1'b0, 1'b0};
  logic        edone[2] = '{1'b0, 1'b0};
  logic        eidle[2] = '{1'b1, 1'b1};

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      for (int u = 0; u < 2; u++) begin
        busy_last[u] = -10;
        clr_edge[u]  = -10;
        eq[u] = 0; er[u] = 0; edbz[u] = 1'b0;
        edone[u] = 1'b0; eidle[u] = 1'b1;
      end
    end else begin
      ec = ec + 1;
      for (int u = 0; u < 2; u++) begin
        if (ec == clr_edge[u]) edbz[u] = 1'b0;
        if (ec == busy_last[u]) begin
          eq[u] = pq[u]; er[u] = pr[u]; edbz[u] = pdbz[u];
        end
        if (s_in[u] && ec > busy_last[u] + 1) begin
          ref_div(WD[u], a_in[u], b_in[u], pq[u], pr[u], pdbz[u]);
          busy_last[u] = ec + (pdbz[u] ? 1 : WD[u] + 1);
          clr_edge[u]  = pdbz[u] ? -10 : ec + 1;
        end
        edone[u] = (ec == busy_last[u]);
        eidle[u] = (ec > busy_last[u]);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      checkOutput($sformatf("u%0d done", u), 32'(done_out[u]), 32'(edone[u]));
      checkOutput($sformatf("u%0d idle", u), 32'(idle_out[u]), 32'(eidle[u]));
      checkOutput($sformatf("u%0d quotient", u), q_out[u], eq[u]);
      checkOutput($sformatf("u%0d remainder", u), r_out[u], er[u]);
      checkOutput($sformatf("u%0d div_by_zero", u), 32'(dbz_out[u]), 32'(edbz[u]));
    end
  end

  // One divide on unit u with hand-computed literal results and latency.
  task automatic applyStimulus(input int u, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] xq, input logic [31:0] xr, input logic xz);
    int lat = (b == 0) ? 2 : WD[u] + 2;
    int n;
    @(negedge clk);
    if (u == 0) begin dvd0 = a[7:0];  dvs0 = b[7:0];  strt0 = 1'b1; end
    else        begin dvd1 = a[15:0]; dvs1 = b[15:0]; strt1 = 1'b1; end
    @(negedge clk);
    strt0 = 1'b0;
    strt1 = 1'b0;
    n = 1;
    checkOutput("lit idle cycle1", 32'(idle_out[u]), 32'd0);
    while (done_out[u] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("lit latency", 32'(n), 32'(lat));
    checkOutput("lit idle at done", 32'(idle_out[u]), 32'd0);
    checkOutput("lit quotient", q_out[u], xq);
    checkOutput("lit remainder", r_out[u], xr);
    checkOutput("lit div_by_zero", 32'(dbz_out[u]), 32'(xz));
  endtask

  initial begin
    int pulses;
    int last;
    int dones;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    checkOutput("reset quotient", q_out[0], 32'd0);
    checkOutput("reset idle", 32'(idle_out[0]), 32'd1);

`ifdef DIVIDER_SIGNED_EN
    applyStimulus(0, 32'hF9, 32'h02, 32'hFD, 32'hFF, 1'b0);
    applyStimulus(0, 32'h07, 32'hFE, 32'hFD, 32'h01, 1'b0);
    applyStimulus(0, 32'h80, 32'hFF, 32'h80, 32'h00, 1'b0);
    applyStimulus(0, 32'hFA, 32'h00, 32'hFF, 32'hFA, 1'b1);
    applyStimulus(0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    applyStimulus(1, 32'hFC18, 32'd7, 32'hFF72, 32'hFFFA, 1'b0);
`else
    applyStimulus(0, 32'd200, 32'd7, 32'd28, 32'd4, 1'b0);
    applyStimulus(0, 32'd5, 32'd0, 32'd255, 32'd5, 1'b1);
    applyStimulus(0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    applyStimulus(0, 32'd3, 32'd9, 32'd0, 32'd3, 1'b0);
    applyStimulus(0, 32'd255, 32'd1, 32'd255, 32'd0, 1'b0);
    applyStimulus(1, 32'd65535, 32'd255, 32'd257, 32'd0, 1'b0);
`endif

    // strt held high: one result every WIDTH+3 cycles.
    pulses = 0;
    last   = -1;
    @(negedge clk);
    dvd0 = 8'd100; dvs0 = 8'd9; strt0 = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      if (done0) begin
        if (last >= 0) checkOutput("hold gap", 32'(i - last), 32'd11);
        checkOutput("hold quotient", 32'(q0), 32'd11);
        last = i;
        pulses++;
      end
    end
    strt0 = 1'b0;
    checkOutput("hold pulses", 32'(pulses), 32'd3);

    // Reset in the middle of CALC on the 16-bit unit.
    @(negedge clk);
    dvd1 = 16'd1000; dvs1 = 16'd7; strt1 = 1'b1;
    @(negedge clk);
    strt1 = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst quotient", q_out[1], 32'd0);
    checkOutput("rst remainder", r_out[1], 32'd0);
    checkOutput("rst idle", 32'(idle_out[1]), 32'd1);
    checkOutput("rst done", 32'(done_out[1]), 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done1) dones++;
    end
    checkOutput("no done after rst", 32'(dones), 32'd0);

    applyStimulus(0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
